lvds_tx_clken_gen: RTL and testbench

//  Multi-channel clock-enable generator for the LVDS TX path, run from the PLL output clock.

---
 rtl/lvds_tx_clken_gen.sv | 123 ++++++++++++
 tb/tb_lvds_tx_clken_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_tx_clken_gen.sv
// Multi-channel clock-enable generator for the LVDS TX path.
// Channels are realigned together on every config change; lock qualifies a stable RUN period.
module lvds_tx_clken_gen #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned LOCK_CNT = 256,
  parameter int unsigned DEF_DIV  = 0
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [$clog2(NUM_CH):0] cfg_ch,
  input  logic [DIV_W-1:0]        cfg_div,
  input  logic [DIV_W-1:0]        cfg_phase,
  output logic [NUM_CH-1:0]       clken,
  output logic                    locked
);

  localparam int unsigned ChW   = $clog2(NUM_CH) + 1;
  localparam int unsigned LockW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {StIdle, StAlign, StRun} state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q   [NUM_CH];
  logic [DIV_W-1:0]  div_d   [NUM_CH];
  logic [DIV_W-1:0]  phase_q [NUM_CH];
  logic [DIV_W-1:0]  phase_d [NUM_CH];
  logic [DIV_W-1:0]  cnt_q   [NUM_CH];
  logic [DIV_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] clken_q, clken_d;
  logic              locked_q, locked_d;
  logic [LockW-1:0]  lock_cnt_q, lock_cnt_d;
  logic              cfg_hit;
  logic              lock_full;

  assign cfg_ready = (state_q != StAlign);
  // Out-of-range channel indices are accepted but otherwise ignored.
  assign cfg_hit   = cfg_valid && cfg_ready && (cfg_ch < ChW'(NUM_CH));
  assign lock_full = (lock_cnt_q == LockW'(LOCK_CNT));
  assign clken     = clken_q;
  assign locked    = locked_q;

  always_comb begin
    state_d    = state_q;
    clken_d    = '0;
    locked_d   = 1'b0;
    lock_cnt_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i]   = div_q[i];
      phase_d[i] = phase_q[i];
      cnt_d[i]   = cnt_q[i];
      if (cfg_hit && (cfg_ch == ChW'(i))) begin
        div_d[i]   = cfg_div;
        phase_d[i] = cfg_phase;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StAlign;
      end
      StAlign: begin
        // Phase beyond the period folds onto the last slot of the period.
        for (int i = 0; i < NUM_CH; i++) begin
          cnt_d[i] = (phase_q[i] < div_q[i]) ? phase_q[i] : div_q[i];
        end
        state_d = StRun;
      end
      StRun: begin
        lock_cnt_d = lock_full ? lock_cnt_q : lock_cnt_q + LockW'(1);
        locked_d   = lock_full;
        for (int i = 0; i < NUM_CH; i++) begin
          if (cnt_q[i] == '0) begin
            clken_d[i] = 1'b1;
            cnt_d[i]   = div_q[i];
          end else begin
            cnt_d[i]   = cnt_q[i] - DIV_W'(1);
          end
        end
        if (cfg_hit) begin
          state_d  = StAlign;
          clken_d  = '0;
          locked_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!enable) begin
      state_d  = StIdle;
      clken_d  = '0;
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q    <= StIdle;
      clken_q    <= '0;
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= DIV_W'(DEF_DIV);
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      clken_q    <= clken_d;
      locked_q   <= locked_d;
      lock_cnt_q <= lock_cnt_d;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= div_d[i];
        phase_q[i] <= phase_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_lvds_tx_clken_gen.sv
// Bench for lvds_tx_clken_gen: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_lvds_tx_clken_gen;

  localparam int unsigned NCH  = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned LCK  = 16;
  localparam int unsigned DDIV = 0;
  localparam int unsigned CW   = $clog2(NCH) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_ch;
  logic [DW-1:0]  cfg_div;
  logic [DW-1:0]  cfg_phase;
  logic [NCH-1:0] clken;
  logic           locked;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lvds_tx_clken_gen #(
    .NUM_CH  (NCH),
    .DIV_W   (DW),
    .LOCK_CNT(LCK),
    .DEF_DIV (DDIV)
  ) dut (
    .refclk   (clk),
    .rst      (rst),
    .enable   (enable),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .clken    (clken),
    .locked   (locked)
  );

  // Model: cycle n is the interval after rising edge n. The run is described by
  // the cycle at which the (re)alignment happened; outputs follow by arithmetic.
  int cyc     = 0;
  bit mvalid  = 1'b0;
  bit running = 1'b0;
  int t_align = 0;
  int m_div [NCH];
  int m_ph  [NCH];

  function automatic logic [NCH-1:0] exp_clken(input int c);
    logic [NCH-1:0] r;
    r = '0;
    if (running) begin
      for (int i = 0; i < NCH; i++) begin
        int m;
        int s;
        m = (m_ph[i] < m_div[i]) ? m_ph[i] : m_div[i];
        s = t_align + 2 + m;
        if (c >= s && ((c - s) % (m_div[i] + 1)) == 0) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic exp_locked(input int c);
    return running && (c >= t_align + int'(LCK) + 2);
  endfunction

  function automatic logic exp_ready(input int c);
    return !(running && c == t_align);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mvalid  = 1'b1;
      running = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_div[i] = DDIV;
        m_ph[i]  = 0;
      end
    end else if (mvalid) begin
      logic acc;
      logic hit;
      acc = cfg_valid && exp_ready(cyc);
      hit = acc && (int'(cfg_ch) < NCH);
      if (hit) begin
        m_div[cfg_ch] = int'(cfg_div);
        m_ph[cfg_ch]  = int'(cfg_phase);
      end
      if (!enable) begin
        running = 1'b0;
      end else if (!running) begin
        running = 1'b1;
        t_align = cyc + 1;
      end else if (hit) begin
        t_align = cyc + 1;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_clken", clken, exp_clken(cyc));
      chk("model_locked", locked, exp_locked(cyc));
      chk("model_ready", cfg_ready, exp_ready(cyc));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic at_cycle(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic wcfg(input int ch, input int dv, input int ph);
    cfg_valid = 1'b1;
    cfg_ch    = CW'(ch);
    cfg_div   = DW'(dv);
    cfg_phase = DW'(ph);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    int w;
    rst       = 1'b1;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    cfg_phase = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_clken", clken, 4'h0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);

    // 1: all div=0, continuous enables, lock after LCK+1 RUN cycles
    step();
    enable = 1'b1;
    t = cyc + 1;
    at_cycle(t);           chk("t1_ready_align", cfg_ready, 1'b0);
    at_cycle(t + 1);       chk("t1_clken_run0", clken, 4'h0);
    at_cycle(t + 2);       chk("t1_clken_first", clken, 4'hF);
    at_cycle(t + 5);       chk("t1_clken_hold", clken, 4'hF);
    at_cycle(t + LCK + 1); chk("t1_locked_early", locked, 1'b0);
    at_cycle(t + LCK + 2); chk("t1_locked_rise", locked, 1'b1);

    // 2: configure in IDLE, then enable
    step();
    enable = 1'b0;
    step();
    wcfg(0, 3, 0);
    wcfg(1, 3, 2);
    enable = 1'b1;
    t = cyc + 1;
    at_cycle(t + 2); chk("t2_clken_t2", clken, 4'b1101);
    at_cycle(t + 3); chk("t2_clken_t3", clken, 4'b1100);
    at_cycle(t + 4); chk("t2_clken_t4", clken, 4'b1110);
    at_cycle(t + 6); chk("t2_clken_t6", clken, 4'b1101);
    at_cycle(t + 8); chk("t2_clken_t8", clken, 4'b1110);
    at_cycle(t + LCK + 2); chk("t2_locked", locked, 1'b1);

    // 3: restarting write while locked
    step();
    w = cyc;
    wcfg(2, 4, 0);
    t = w + 1;
    at_cycle(t);           chk("t3_ready_low", cfg_ready, 1'b0);
                           chk("t3_locked_drop", locked, 1'b0);
    at_cycle(t + 1);       chk("t3_ready_back", cfg_ready, 1'b1);
    at_cycle(t + 2);       chk("t3_clken_t2", clken, 4'b1101);
    at_cycle(t + 7);       chk("t3_clken_t7", clken, 4'b1100);
    at_cycle(t + LCK + 1); chk("t3_locked_early", locked, 1'b0);
    at_cycle(t + LCK + 2); chk("t3_locked_back", locked, 1'b1);

    // 4: out-of-range channel write is harmless
    step();
    w = cyc;
    wcfg(NCH, 1, 1);
    at_cycle(w + 1); chk("t4_ready", cfg_ready, 1'b1);
                     chk("t4_locked", locked, 1'b1);
    at_cycle(w + 3); chk("t4_locked_hold", locked, 1'b1);

    // 5: phase beyond div folds; enable drop with simultaneous write
    step();
    w = cyc;
    wcfg(3, 3, 9);
    t = w + 1;
    at_cycle(t + 4); chk("t5_ch3_early", clken[3], 1'b0);
    at_cycle(t + 5); chk("t5_clken_t5", clken, 4'b1000);
    at_cycle(t + 9); chk("t5_ch3_t9", clken[3], 1'b1);
    step();
    w = cyc;
    enable    = 1'b0;
    cfg_valid = 1'b1;
    cfg_ch    = CW'(3);
    cfg_div   = DW'(5);
    cfg_phase = DW'(0);
    step();
    cfg_valid = 1'b0;
    at_cycle(w + 1); chk("t5_idle_clken", clken, 4'h0);
                     chk("t5_idle_locked", locked, 1'b0);
                     chk("t5_idle_ready", cfg_ready, 1'b1);
    step();
    enable = 1'b1;
    t = cyc + 1;
    at_cycle(t + 7); chk("t5_clken_t7", clken, 4'b0100);
    at_cycle(t + 8); chk("t5_clken_t8", clken, 4'b1010);

    // 6: reset mid-RUN returns to defaults
    at_cycle(t + 10);
    step();
    w = cyc;
    rst = 1'b1;
    step();
    rst = 1'b0;
    at_cycle(w + 1); chk("t6_clken_rst", clken, 4'h0);
                     chk("t6_locked_rst", locked, 1'b0);
    at_cycle(w + 2); chk("t6_ready_align", cfg_ready, 1'b0);
    at_cycle(w + 3); chk("t6_clken_run0", clken, 4'h0);
    at_cycle(w + 4); chk("t6_clken_def", clken, 4'hF);
    at_cycle(w + 8); chk("t6_clken_def_hold", clken, 4'hF);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
